// File: rtl/sop_truth_scanner_pkg.sv
// Shared definitions for the SOP truth-table scanner: FSM encoding, vector count
// and the mismatch popcount helper.
package sop_truth_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sop_truth_scanner_dwell_timer.sv
// Per-vector dwell counter: counts 0..DWELL-1 while enabled and wraps on tick.
module sop_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sop_truth_scanner.sv
// Exhaustive on-chip scan of a 4-input SOP block: drives all 16 minterms, samples
// the response at the end of each dwell window and grades it against EXPECTED.
module sop_truth_scanner
  import sop_truth_scanner_pkg::*;
#(
  parameter int unsigned DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  input  logic        sop_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth,
  output logic [4:0]  mismatches
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        truth_q, truth_d;
  logic [4:0]         mism_q, mism_d;
  logic               launch;
  logic               tick;
  logic               last_vec;

  assign launch   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_vec = (idx_q == IDX_W'(NUM_VEC - 1));

  sop_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .en    (state_q == S_DRIVE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: if (tick && last_vec) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_DRIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // The final sample is folded into the mismatch count on the same edge that enters DONE.
  always_comb begin
    idx_d   = idx_q;
    truth_d = truth_q;
    mism_d  = mism_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          idx_d   = '0;
          truth_d = '0;
          mism_d  = '0;
        end
      end
      S_DRIVE: begin
        if (tick) begin
          truth_d[idx_q] = sop_out;
          if (last_vec) begin
            mism_d = popcount16(truth_d ^ EXPECTED);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: idx_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      truth_q <= '0;
      mism_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      truth_q <= truth_d;
      mism_q  <= mism_d;
    end
  end

  always_comb begin
    busy = (state_q == S_DRIVE);
    done = (state_q == S_DONE);
    pass = done && (truth_q == EXPECTED);
  end

  assign {A, B, C, D} = idx_q;
  assign truth        = truth_q;
  assign mismatches   = mism_q;

endmodule

// File: tb/tb_sop_truth_scanner.sv
// Directed bench: four scanner instances (DWELL 4/4/2/255) each driving an A&B|C&D model.
module tb_sop_truth_scanner;

  logic        clk;
  logic [3:0]  rst_v;
  logic [3:0]  start_v;
  logic [3:0]  abcd_v  [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        pass_v  [4];
  logic [15:0] truth_v [4];
  logic [4:0]  mm_v    [4];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned DW  = (g == 2) ? 2 : (g == 3) ? 255 : 4;
    localparam logic [15:0] EXP = (g == 1) ? 16'hF889 : 16'hF888;
    logic a, b, c, d, sop;
    assign sop       = (a & b) | (c & d);
    assign abcd_v[g] = {a, b, c, d};
    sop_truth_scanner #(.DWELL(DW), .EXPECTED(EXP)) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .start      (start_v[g]),
      .A          (a),
      .B          (b),
      .C          (c),
      .D          (d),
      .sop_out    (sop),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .pass       (pass_v[g]),
      .truth      (truth_v[g]),
      .mismatches (mm_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start_v[n] = 1'b1;
    @(posedge clk);
    #1;
    start_v[n] = 1'b0;
  endtask

  task automatic run_scan(input int n, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done_v[n]) break;
    end
  endtask

  initial begin
    rst_v   = 4'hF;
    start_v = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 4'h0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_abcd",  32'(abcd_v[0]),  32'h0);
    check("rst_busy",  32'(busy_v[0]),  32'h0);
    check("rst_done",  32'(done_v[0]),  32'h0);
    check("rst_pass",  32'(pass_v[0]),  32'h0);
    check("rst_truth", 32'(truth_v[0]), 32'h0);
    check("rst_mm",    32'(mm_v[0]),    32'h0);

    // Clean scan, DWELL=4
    pulse_start(0);
    check("t2_busy", 32'(busy_v[0]), 32'h1);
    run_scan(0, 100, lat);
    check("t2_latency", 32'(lat),          32'd64);
    check("t2_truth",   32'(truth_v[0]),   32'hF888);
    check("t2_pass",    32'(pass_v[0]),    32'h1);
    check("t2_mm",      32'(mm_v[0]),      32'h0);
    check("t2_busy_end",32'(busy_v[0]),    32'h0);
    check("t2_idx_hold",32'(abcd_v[0]),    32'hF);

    // Golden off by one bit; watch vector 0101 hold for four cycles
    pulse_start(1);
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk);
      #1;
      lat = j;
      if (j >= 19 && j <= 24) check($sformatf("t3_abcd_c%0d", j), 32'(abcd_v[1]), 32'(j / 4));
      if (done_v[1]) break;
    end
    check("t3_latency", 32'(lat),        32'd64);
    check("t3_truth",   32'(truth_v[1]), 32'hF888);
    check("t3_pass",    32'(pass_v[1]),  32'h0);
    check("t3_mm",      32'(mm_v[1]),    32'h1);

    // start pulses mid-scan are ignored
    pulse_start(0);
    lat = 0;
    while (lat < 100) begin
      start_v[0] = ((lat + 1) == 10) || ((lat + 1) == 30);
      @(posedge clk);
      #1;
      lat++;
      if (done_v[0]) break;
    end
    start_v[0] = 1'b0;
    check("t4_latency", 32'(lat),        32'd64);
    check("t4_truth",   32'(truth_v[0]), 32'hF888);

    // Reset at cycle 20 aborts; fresh scan afterwards
    pulse_start(0);
    repeat (19) @(posedge clk);
    #1;
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    check("t5_busy",  32'(busy_v[0]),  32'h0);
    check("t5_done",  32'(done_v[0]),  32'h0);
    check("t5_truth", 32'(truth_v[0]), 32'h0);
    check("t5_abcd",  32'(abcd_v[0]),  32'h0);
    @(posedge clk);
    #1;
    check("t5_idle", 32'(busy_v[0]), 32'h0);
    pulse_start(0);
    run_scan(0, 100, lat);
    check("t5_latency", 32'(lat),        32'd64);
    check("t5_truth",   32'(truth_v[0]), 32'hF888);
    check("t5_pass",    32'(pass_v[0]),  32'h1);

    // Restart from DONE
    pulse_start(0);
    check("t6_abcd",  32'(abcd_v[0]),  32'h0);
    check("t6_busy",  32'(busy_v[0]),  32'h1);
    check("t6_done",  32'(done_v[0]),  32'h0);
    check("t6_truth", 32'(truth_v[0]), 32'h0);
    run_scan(0, 100, lat);
    check("t6_latency", 32'(lat),        32'd64);
    check("t6_truth2",  32'(truth_v[0]), 32'hF888);

    // start together with rst has no effect
    @(negedge clk);
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    check("t6_rst_busy", 32'(busy_v[0]), 32'h0);
    check("t6_rst_done", 32'(done_v[0]), 32'h0);
    @(posedge clk);
    #1;
    check("t6_rst_idle", 32'(busy_v[0]), 32'h0);

    // DWELL sweep
    pulse_start(2);
    run_scan(2, 60, lat);
    check("dw2_latency", 32'(lat),        32'd32);
    check("dw2_truth",   32'(truth_v[2]), 32'hF888);
    check("dw2_pass",    32'(pass_v[2]),  32'h1);
    pulse_start(3);
    run_scan(3, 4200, lat);
    check("dw255_latency", 32'(lat),        32'd4080);
    check("dw255_truth",   32'(truth_v[3]), 32'hF888);
    check("dw255_pass",    32'(pass_v[3]),  32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
